// File: rtl/pc_sequencer_if.sv
// Fetch-side bus of the program-counter sequencer: control inputs and address outputs.
// master = sequencer (drives pc), slave = controller/instruction-memory side.
interface pc_sequencer_if;
    logic       start;
    logic       pc_ready;
    logic       jump_en;
    logic [7:0] jump_addr;
    logic [7:0] pc;
    logic       pc_valid;
    logic       busy;
    logic       halted;
    logic [7:0] issue_cnt;

    modport master (
        input  start, pc_ready, jump_en, jump_addr,
        output pc, pc_valid, busy, halted, issue_cnt
    );

    modport slave (
        output start, pc_ready, jump_en, jump_addr,
        input  pc, pc_valid, busy, halted, issue_cnt
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues RESET_PC..END_PC, takes jump redirects with a one-cycle bubble.
// Optional accepted-address counter enabled by the macro PC_ISSUE_CNT_EN.
module pc_sequencer #(
    parameter logic [7:0] RESET_PC = 8'd1,
    parameter logic [7:0] END_PC   = 8'd5
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_BUBBLE = 2'd2,
        S_HALT   = 2'd3
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic       hs;

    assign hs = (state_q == S_RUN) && bus.pc_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_RUN;
                    pc_d    = RESET_PC;
                end
            end
            S_RUN: begin
                // A jump wins over any handshake; the accepted old pc still counts as issued.
                if (bus.jump_en) begin
                    pc_d    = bus.jump_addr;
                    state_d = S_BUBBLE;
                end else if (hs && (pc_q == END_PC)) begin
                    state_d = S_HALT;
                end else if (hs) begin
                    pc_d = pc_q + 8'd1;
                end
            end
            S_BUBBLE: begin
                if (bus.jump_en) begin
                    pc_d = bus.jump_addr;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                if (bus.start) begin
                    pc_d    = RESET_PC;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_ISSUE_CNT_EN
    logic [7:0] issue_cnt_q, issue_cnt_d;

    // Restart clears the count; a handshake cannot coincide with it since HALT never handshakes.
    always_comb begin
        issue_cnt_d = issue_cnt_q;
        if ((state_q == S_HALT) && bus.start) begin
            issue_cnt_d = 8'd0;
        end else if (hs && (issue_cnt_q != 8'd255)) begin
            issue_cnt_d = issue_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            issue_cnt_q <= 8'd0;
        end else begin
            issue_cnt_q <= issue_cnt_d;
        end
    end

    assign bus.issue_cnt = issue_cnt_q;
`else
    assign bus.issue_cnt = 8'd0;
`endif

    assign bus.pc       = pc_q;
    assign bus.pc_valid = (state_q == S_RUN);
    assign bus.busy     = (state_q == S_RUN) || (state_q == S_BUBBLE);
    assign bus.halted   = (state_q == S_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios plus randomized traffic against a behavioural model.
// Honors PC_ISSUE_CNT_EN the same way as the design.
module tb_pc_sequencer;

    localparam logic [7:0] RESET_PC = 8'd1;
    localparam logic [7:0] END_PC   = 8'd5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pc_sequencer_if bus ();

    pc_sequencer #(.RESET_PC(RESET_PC), .END_PC(END_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total  = 0;

    // Behavioural model: "what is the fetcher doing" flags plus address and accepted count.
    logic       m_idle, m_fetching, m_flushing, m_stopped;
    logic [7:0] m_pc;
    int         m_accepted;

    task automatic model_step();
        logic accepted;
        if (!rst_n) begin
            m_idle = 1; m_fetching = 0; m_flushing = 0; m_stopped = 0;
            m_pc = RESET_PC; m_accepted = 0;
        end else if (m_idle) begin
            if (bus.start) begin m_idle = 0; m_fetching = 1; m_pc = RESET_PC; end
        end else if (m_fetching) begin
            accepted = bus.pc_ready;
            if (accepted) m_accepted = (m_accepted >= 255) ? 255 : m_accepted + 1;
            if (bus.jump_en) begin
                m_pc = bus.jump_addr; m_fetching = 0; m_flushing = 1;
            end else if (accepted && m_pc == END_PC) begin
                m_fetching = 0; m_stopped = 1;
            end else if (accepted) begin
                m_pc = 8'((int'(m_pc) + 1) % 256);
            end
        end else if (m_flushing) begin
            if (bus.jump_en) m_pc = bus.jump_addr;
            else begin m_flushing = 0; m_fetching = 1; end
        end else if (m_stopped) begin
            if (bus.start) begin
                m_stopped = 0; m_fetching = 1; m_pc = RESET_PC; m_accepted = 0;
            end
        end
    endtask

    function automatic logic [7:0] cnt_exp(input int n);
`ifdef PC_ISSUE_CNT_EN
        return 8'(n);
`else
        return 8'd0;
`endif
    endfunction

    function automatic logic [18:0] model_vec();
        return {m_pc, m_fetching, m_fetching | m_flushing, m_stopped, cnt_exp(m_accepted)};
    endfunction

    function automatic logic [18:0] dut_vec();
        return {bus.pc, bus.pc_valid, bus.busy, bus.halted, bus.issue_cnt};
    endfunction

    // Inputs are stable across the rising edge; outputs are observed on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; bus.start = 1; bus.jump_en = 1; bus.pc_ready = 1;
        tick(); tick();
        bus.start = 0; bus.jump_en = 0;
        total++;
        if ({bus.pc, bus.pc_valid, bus.busy, bus.halted, bus.issue_cnt} !== {RESET_PC, 3'b000, 8'd0}) begin
            $display("FAIL reset_state: pc=%0d valid=%0b busy=%0b halted=%0b cnt=%0d, want pc=%0d and all flags/count 0",
                     bus.pc, bus.pc_valid, bus.busy, bus.halted, bus.issue_cnt, RESET_PC);
        end else passed++;
        rst_n = 1;
        tick();
        total++;
        if (bus.pc_valid !== 1'b0 || bus.busy !== 1'b0) begin
            $display("FAIL idle_no_start: valid=%0b busy=%0b, want 0 0", bus.pc_valid, bus.busy);
        end else passed++;
    endtask

    task automatic test_basic_run();
        bus.pc_ready = 1; bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (bus.pc !== RESET_PC + 8'(i) || bus.pc_valid !== 1'b1 || bus.busy !== 1'b1) begin
                $display("FAIL basic_seq[%0d]: pc=%0d valid=%0b busy=%0b, want pc=%0d valid=1 busy=1",
                         i, bus.pc, bus.pc_valid, bus.busy, RESET_PC + 8'(i));
            end else passed++;
            tick();
        end
        total++;
        if (bus.halted !== 1'b1 || bus.pc_valid !== 1'b0 || bus.pc !== END_PC || bus.issue_cnt !== cnt_exp(5)) begin
            $display("FAIL basic_halt: halted=%0b valid=%0b pc=%0d cnt=%0d, want 1 0 %0d %0d",
                     bus.halted, bus.pc_valid, bus.pc, bus.issue_cnt, END_PC, cnt_exp(5));
        end else passed++;
    endtask

    task automatic test_halt_restart();
        bus.jump_en = 1; bus.jump_addr = 8'd3;
        tick();
        bus.jump_en = 0;
        total++;
        if (bus.halted !== 1'b1 || bus.pc !== END_PC || bus.pc_valid !== 1'b0) begin
            $display("FAIL halt_ignores_jump: halted=%0b pc=%0d valid=%0b, want 1 %0d 0",
                     bus.halted, bus.pc, bus.pc_valid, END_PC);
        end else passed++;
        bus.start = 1;
        tick();
        bus.start = 0;
        total++;
        if (bus.pc !== RESET_PC || bus.pc_valid !== 1'b1 || bus.halted !== 1'b0 || bus.issue_cnt !== 8'd0) begin
            $display("FAIL restart: pc=%0d valid=%0b halted=%0b cnt=%0d, want %0d 1 0 0",
                     bus.pc, bus.pc_valid, bus.halted, bus.issue_cnt, RESET_PC);
        end else passed++;
    endtask

    task automatic test_stall();
        bus.pc_ready = 1;
        tick(); tick();
        bus.pc_ready = 0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if (bus.pc !== 8'd3 || bus.pc_valid !== 1'b1) begin
                $display("FAIL stall_hold[%0d]: pc=%0d valid=%0b, want 3 1", i, bus.pc, bus.pc_valid);
            end else passed++;
            tick();
        end
        bus.pc_ready = 1;
        tick();
        total++;
        if (bus.pc !== 8'd4 || bus.pc_valid !== 1'b1) begin
            $display("FAIL stall_release: pc=%0d valid=%0b, want 4 1", bus.pc, bus.pc_valid);
        end else passed++;
    endtask

    task automatic test_jump();
        logic [7:0] e;
        bus.jump_en = 1; bus.jump_addr = 8'd2;
        tick();
        bus.jump_en = 0;
        total++;
        if (bus.pc_valid !== 1'b0 || bus.busy !== 1'b1) begin
            $display("FAIL jump_bubble: valid=%0b busy=%0b, want 0 1", bus.pc_valid, bus.busy);
        end else passed++;
        tick();
        total++;
        if (bus.pc !== 8'd2 || bus.pc_valid !== 1'b1 || bus.issue_cnt !== cnt_exp(4)) begin
            $display("FAIL jump_target: pc=%0d valid=%0b cnt=%0d, want 2 1 %0d",
                     bus.pc, bus.pc_valid, bus.issue_cnt, cnt_exp(4));
        end else passed++;
        e = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (bus.pc !== e || bus.pc_valid !== 1'b1) begin
                $display("FAIL jump_continue[%0d]: pc=%0d valid=%0b, want %0d 1", i, bus.pc, bus.pc_valid, e);
            end else passed++;
            e++;
        end
        tick();
        total++;
        if (bus.halted !== 1'b1 || bus.issue_cnt !== cnt_exp(8)) begin
            $display("FAIL jump_halt: halted=%0b cnt=%0d, want 1 %0d", bus.halted, bus.issue_cnt, cnt_exp(8));
        end else passed++;
    endtask

    task automatic test_wrap();
        logic [7:0] e;
        bus.start = 1; tick(); bus.start = 0;
        bus.jump_en = 1; bus.jump_addr = 8'd254; tick(); bus.jump_en = 0;
        tick();
        e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (bus.pc !== e || bus.pc_valid !== 1'b1) begin
                $display("FAIL wrap_seq[%0d]: pc=%0d valid=%0b, want %0d 1", i, bus.pc, bus.pc_valid, e);
            end else passed++;
            e++;
            tick();
        end
        total++;
        if (bus.halted !== 1'b1 || bus.pc !== END_PC) begin
            $display("FAIL wrap_halt: halted=%0b pc=%0d, want 1 %0d", bus.halted, bus.pc, END_PC);
        end else passed++;
    endtask

    task automatic test_reset_bubble();
        bus.start = 1; tick(); bus.start = 0;
        bus.jump_en = 1; bus.jump_addr = 8'd3; tick(); bus.jump_en = 0;
        rst_n = 0; tick(); rst_n = 1;
        total++;
        if ({bus.pc, bus.pc_valid, bus.busy, bus.halted, bus.issue_cnt} !== {RESET_PC, 3'b000, 8'd0}) begin
            $display("FAIL reset_in_bubble: pc=%0d valid=%0b busy=%0b halted=%0b cnt=%0d, want %0d 0 0 0 0",
                     bus.pc, bus.pc_valid, bus.busy, bus.halted, bus.issue_cnt, RESET_PC);
        end else passed++;
        bus.start = 1; tick(); bus.start = 0;
        total++;
        if (bus.pc !== RESET_PC || bus.pc_valid !== 1'b1) begin
            $display("FAIL resume_after_reset: pc=%0d valid=%0b, want %0d 1", bus.pc, bus.pc_valid, RESET_PC);
        end else passed++;
    endtask

    task automatic test_saturate();
        bus.pc_ready = 1;
        bus.jump_en = 1; bus.jump_addr = 8'd6; tick(); bus.jump_en = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL saturate[%0d]: dut pc/valid/busy/halted/cnt=%h, want %h", i, dut_vec(), model_vec());
            end else passed++;
        end
        total++;
        if (bus.halted !== 1'b1 || bus.issue_cnt !== cnt_exp(255)) begin
            $display("FAIL saturate_end: halted=%0b cnt=%0d, want 1 %0d", bus.halted, bus.issue_cnt, cnt_exp(255));
        end else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            rst_n         = ($urandom_range(0, 299) != 0);
            bus.start     = ($urandom_range(0, 7) == 0);
            bus.pc_ready  = ($urandom_range(0, 3) != 0);
            bus.jump_en   = ($urandom_range(0, 9) == 0);
            bus.jump_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 7)) : 8'($urandom);
            tick();
            total++;
            if (dut_vec() !== model_vec()) begin
                $display("FAIL random[%0d]: dut pc/valid/busy/halted/cnt=%h, want %h", i, dut_vec(), model_vec());
            end else passed++;
        end
        rst_n = 1; bus.start = 0; bus.jump_en = 0;
    endtask

    initial begin
        bus.start = 0; bus.pc_ready = 0; bus.jump_en = 0; bus.jump_addr = 8'd0;
        m_idle = 1; m_fetching = 0; m_flushing = 0; m_stopped = 0; m_pc = RESET_PC; m_accepted = 0;
        @(negedge clk);
        test_reset();
        test_basic_run();
        test_halt_restart();
        test_stall();
        test_jump();
        test_wrap();
        test_reset_bubble();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
